// File: rtl/bdu_accum.sv
// bdu_accum: squared-distance accumulator with early prune for topK.
// Optional RUNNING_MEAN_EN adds an EMA running_mean.
`ifndef DIST_WIDTH
`define DIST_WIDTH 16
`endif

package bdu_pkg;
   typedef struct packed {
      logic [`DIST_WIDTH-1:0] distance;
      logic                   valid;
   } knn_entry_t;
endpackage

module bdu_accum
   import bdu_pkg::*;
#(
   parameter int ELEM_WIDTH = 8,
   parameter int MEAN_INIT  = 50,
   parameter int MEAN_SHIFT = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_last,
   input  logic [ELEM_WIDTH-1:0]  query_elem,
   input  logic [ELEM_WIDTH-1:0]  cand_elem,
   input  logic [`DIST_WIDTH-1:0] threshold,
   output logic                   bdu_done,
   output knn_entry_t             bdu_entry,
   output logic [`DIST_WIDTH-1:0] running_mean,
   output logic                   busy
);

   localparam int DW = `DIST_WIDTH;
   localparam int SW = 2 * ELEM_WIDTH;
   localparam int XW = ((DW > SW) ? DW : SW) + 1;
   localparam logic [DW-1:0] DMAX = '1;

   typedef enum logic [1:0] {IDLE, ACCUM, SKIP, DONE} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   acc_q, acc_d;
   logic [DW-1:0]   thr_q, thr_d;
   logic [DW-1:0]   thr_cmp, acc_sat;
   logic            pruned_q, pruned_d;
   logic            take, load_entry;
   logic [ELEM_WIDTH-1:0] diff;
   logic [SW-1:0]   sq;
   logic [XW-1:0]   sum;
   knn_entry_t      entry_q;

   assign in_ready = (state_q != DONE);
   assign busy     = (state_q != IDLE);
   assign bdu_done = (state_q == DONE);
   assign take     = in_valid && in_ready;

   assign diff = (query_elem >= cand_elem) ? query_elem - cand_elem
                                           : cand_elem - query_elem;
   assign sq   = SW'(diff) * SW'(diff);
   assign sum  = XW'(acc_q) + XW'(sq);
   assign acc_sat = (sum > XW'(DMAX)) ? DMAX : sum[DW-1:0];

   // First element compares against the live threshold, later ones the latch
   assign thr_cmp = (state_q == IDLE) ? threshold : thr_q;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      thr_d    = thr_q;
      pruned_d = pruned_q;
      unique case (state_q)
         IDLE, ACCUM: begin
            if (take) begin
               if (state_q == IDLE)
                  thr_d = threshold;
               acc_d = acc_sat;
               if (acc_sat > thr_cmp) begin
                  pruned_d = 1'b1;
                  state_d  = in_last ? DONE : SKIP;
               end else begin
                  state_d  = in_last ? DONE : ACCUM;
               end
            end
         end
         SKIP: begin
            if (take && in_last)
               state_d = DONE;
         end
         DONE: begin
            acc_d    = '0;
            pruned_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   assign load_entry = (state_d == DONE) && (state_q != DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         thr_q    <= '0;
         pruned_q <= 1'b0;
         entry_q  <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         thr_q    <= thr_d;
         pruned_q <= pruned_d;
         if (load_entry) begin
            entry_q.distance <= acc_d;
            entry_q.valid    <= !pruned_d;
         end
      end
   end

   assign bdu_entry = entry_q;

`ifdef RUNNING_MEAN_EN
   logic [DW-1:0]      mean_q;
   logic signed [DW:0] delta, step, mean_nxt;

   assign delta    = $signed({1'b0, entry_q.distance}) - $signed({1'b0, mean_q});
   assign step     = delta >>> MEAN_SHIFT;
   assign mean_nxt = $signed({1'b0, mean_q}) + step;

   always_ff @(posedge clk) begin
      if (reset)
         mean_q <= DW'(MEAN_INIT);
      else if (state_q == DONE)
         mean_q <= mean_nxt[DW-1:0];
   end

   assign running_mean = mean_q;
`else
   assign running_mean = DW'(MEAN_INIT);
`endif

endmodule

// File: tb/tb_bdu_accum.sv
// tb_bdu_accum: randomized scoreboard bench for bdu_accum.
// Directed candidates first, then random candidates with gaps and aborts.
`ifndef DIST_WIDTH
`define DIST_WIDTH 16
`endif

module tb_bdu_accum;
   import bdu_pkg::*;

   localparam int     DW         = `DIST_WIDTH;
   localparam longint MAXD       = (longint'(1) << DW) - 1;
   localparam int     MEAN_INIT  = 50;
   localparam int     MEAN_SHIFT = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic [7:0]    query_elem = '0;
   logic [7:0]    cand_elem = '0;
   logic [DW-1:0] threshold = '1;
   logic          in_ready, bdu_done, busy;
   logic [DW-1:0] running_mean;
   knn_entry_t    bdu_entry;

   bdu_accum #(
      .ELEM_WIDTH (8),
      .MEAN_INIT  (MEAN_INIT),
      .MEAN_SHIFT (MEAN_SHIFT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_last      (in_last),
      .query_elem   (query_elem),
      .cand_elem    (cand_elem),
      .threshold    (threshold),
      .bdu_done     (bdu_done),
      .bdu_entry    (bdu_entry),
      .running_mean (running_mean),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint d;
      bit     v;
   } exp_t;

   exp_t   sb[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   bit     pend = 0;
   longint mdl_mean = MEAN_INIT;
   int     qv[8];
   int     cv[8];

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: checks done timing, handshake and pops the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         chk("done_timing", longint'(bdu_done), longint'(pend));
         chk("in_ready", longint'(in_ready), longint'(!pend));
         pend = 0;
         if (bdu_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("distance", longint'(bdu_entry.distance), e.d);
               chk("valid", longint'(bdu_entry.valid), longint'(e.v));
               chk("running_mean", longint'(running_mean), mdl_mean);
`ifdef RUNNING_MEAN_EN
               mdl_mean = mdl_mean + ((e.d - mdl_mean) >>> MEAN_SHIFT);
`endif
            end
         end
      end
   end

   task automatic send(input int q, input int c, input bit last,
                       input longint thr, output bit ok);
      int tries;
      bit rdy;
      tries = 0;
      ok = 0;
      if ($urandom_range(0, 4) == 0) begin
         in_valid   = 1'b0;
         query_elem = 8'($urandom);
         cand_elem  = 8'($urandom);
         @(posedge clk);
         #1;
      end
      while (!ok && tries < 8) begin
         in_valid   = 1'b1;
         query_elem = 8'(q);
         cand_elem  = 8'(c);
         in_last    = last;
         threshold  = DW'(thr);
         rdy = in_ready;
         @(posedge clk);
         #1;
         tries++;
         if (rdy) ok = 1;
      end
      in_valid = 1'b0;
      if (!ok)
         chk("accept_timeout", 0, 1);
      else if (last)
         pend = 1;
   endtask

   task automatic cand(input int n, input longint thr0, input longint thr1,
                       input int abort_at, input bit has_exp,
                       input longint ed, input bit ev);
      longint s;
      longint d;
      bit pr;
      bit ok;
      exp_t e;
      s = 0;
      pr = 0;
      for (int i = 0; i < n; i++) begin
         if (i == abort_at) begin
            reset    = 1'b1;
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            reset = 1'b0;
            mdl_mean = MEAN_INIT;
            chk("abort_busy", longint'(busy), 0);
            chk("abort_ready", longint'(in_ready), 1);
            return;
         end
         send(qv[i], cv[i], i == n - 1, (i == 0) ? thr0 : thr1, ok);
         if (!pr) begin
            d = (qv[i] > cv[i]) ? qv[i] - cv[i] : cv[i] - qv[i];
            s = s + d * d;
            if (s > MAXD) s = MAXD;
            if (s > thr0) pr = 1;
         end
      end
      if (has_exp) begin
         e.d = ed;
         e.v = ev;
      end else begin
         e.d = s;
         e.v = !pr;
      end
      sb.push_back(e);
   endtask

   task automatic fill(input int q0, input int c0, input int c1,
                       input int c2, input int c3);
      for (int i = 0; i < 8; i++) qv[i] = q0;
      cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = c3;
   endtask

   initial begin
      int n;
      longint t0, t1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_done", longint'(bdu_done), 0);
      chk("rst_entry", longint'(bdu_entry), 0);
      chk("rst_mean", longint'(running_mean), MEAN_INIT);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_ready", longint'(in_ready), 1);

      fill(0, 1, 2, 3, 4);
      cand(4, MAXD, MAXD, -1, 1, 30, 1);
      fill(0, 6, 5, 0, 0);
      cand(2, MAXD, MAXD, -1, 1, 61, 1);
      fill(0, 3, 3, 3, 3);
      cand(4, 10, 10, -1, 1, 18, 0);
      fill(0, 2, 2, 2, 2);
      cand(4, 20, 5, -1, 1, 16, 1);
      cand(4, 16, 16, -1, 1, 16, 1);
      fill(0, 255, 0, 0, 0);
      cand(1, MAXD, MAXD, -1, 1, (65025 < MAXD) ? 65025 : MAXD, 1);
      fill(0, 1, 1, 1, 1);
      cand(4, MAXD, MAXD, 2, 0, 0, 0);
      cand(4, MAXD, MAXD, -1, 1, 4, 1);

      for (int k = 0; k < 300; k++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < 8; i++) begin
            qv[i] = $urandom_range(0, 255);
            cv[i] = $urandom_range(0, 255);
         end
         case ($urandom_range(0, 2))
            0: t0 = MAXD;
            1: t0 = $urandom_range(0, 3000);
            default: t0 = longint'($urandom) & MAXD;
         endcase
         t1 = ($urandom_range(0, 1) == 0) ? t0 : (longint'($urandom) & MAXD);
         if (n >= 2 && $urandom_range(0, 11) == 0)
            cand(n, t0, t1, $urandom_range(1, n - 1), 0, 0, 0);
         else
            cand(n, t0, t1, -1, 0, 0, 0);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("sb_drain", sb.size(), 0);
      chk("final_mean", longint'(running_mean), mdl_mean);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
